// File: rtl/airlock_pkg.sv
// Shared airlock types: sequencer state, door-cycle direction, default timing constants
// and the Moore output decode used by airlock_sequencer.
package airlock_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_OUTER_OPEN = 3'd1,
    S_OUTER_WAIT = 3'd2,
    S_FILL       = 3'd3,
    S_INNER_OPEN = 3'd4,
    S_INNER_WAIT = 3'd5,
    S_EVAC       = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  typedef enum logic {
    DIR_ARRIVE = 1'b0,
    DIR_DEPART = 1'b1
  } dir_t;

  localparam int DEFAULT_DWELL        = 8;
  localparam int DEFAULT_FILL_TIMEOUT = 64;
  localparam int DEFAULT_DOOR_TIMEOUT = 32;
  localparam int DEFAULT_CW           = 8;

  typedef struct packed {
    logic open_outer;
    logic open_inner;
    logic begin_fandp;
    logic begin_evac;
    logic busy;
    logic fault;
  } outs_t;

  // Each command belongs to exactly one state, so door and stage requests are
  // mutually exclusive by construction.
  function automatic outs_t decode_outputs(state_t s);
    outs_t o;
    o      = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_OUTER_OPEN: o.open_outer  = 1'b1;
      S_INNER_OPEN: o.open_inner  = 1'b1;
      S_FILL:       o.begin_fandp = 1'b1;
      S_EVAC:       o.begin_evac  = 1'b1;
      S_FAULT:      o.fault       = 1'b1;
      default:      ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/airlock_timer.sv
// Loadable down-counter shared by all sequencer states; holds at zero and
// flags done while the count is zero.
module airlock_timer
  import airlock_pkg::*;
#(
  parameter int CW = DEFAULT_CW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          done
);

  logic [CW-1:0] r_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign value = r_count;
  assign done  = (r_count == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock chamber sequencer: Moore FSM driving door-open, fill and evacuation requests.
// Optional watchdogs on FILL/EVAC, the door waits and the fill-stage acknowledge are built with AIRLOCK_TIMEOUT_EN.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int DWELL        = DEFAULT_DWELL,
  parameter int FILL_TIMEOUT = DEFAULT_FILL_TIMEOUT,
  parameter int DOOR_TIMEOUT = DEFAULT_DOOR_TIMEOUT,
  parameter int CW           = DEFAULT_CW
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          ArriveReq,
  input  logic          DepartReq,
  input  logic          OuterClosed,
  input  logic          InnerClosed,
  input  logic          Pressurized,
  input  logic          Depressurized,
  input  logic          FandP,
  output logic          begin_FandP,
  output logic          begin_Evac,
  output logic          OpenOuter,
  output logic          OpenInner,
  output logic          Busy,
  output logic          Fault,
  output logic [2:0]    o_dbg_state,
  output logic          o_dbg_dir,
  output logic          o_dbg_fandp_seen,
  output logic [CW-1:0] o_dbg_count
);

  // Timer is loaded with N-1 so a state lasting N cycles leaves on the done cycle.
  localparam logic [CW-1:0] LD_DWELL = CW'(DWELL - 1);
  localparam logic [CW-1:0] LD_FILL  = CW'(FILL_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_DOOR  = CW'(DOOR_TIMEOUT - 1);
`ifdef AIRLOCK_TIMEOUT_EN
  // Count value during the second FILL cycle: last chance to see FandP.
  localparam logic [CW-1:0] LD_FANDP_LAST = CW'(FILL_TIMEOUT - 2);
`endif

  state_t        r_state;
  state_t        w_next;
  dir_t          r_dir;
  dir_t          w_next_dir;
  logic          r_fandp_seen;
  logic          w_fandp_seen_next;
  logic          w_load;
  logic [CW-1:0] w_load_value;
  logic [CW-1:0] w_count;
  logic          w_done;
  logic          w_fill_late;
  outs_t         w_outs;

  airlock_timer #(.CW(CW)) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (w_load),
    .load_value (w_load_value),
    .value      (w_count),
    .done       (w_done)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_dir        <= DIR_ARRIVE;
      r_fandp_seen <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_dir        <= w_next_dir;
      r_fandp_seen <= w_fandp_seen_next;
    end
  end

  // Tracks whether the fill stage has acknowledged during the current FILL visit.
  assign w_fandp_seen_next = (r_state == S_FILL) && (w_next == S_FILL) &&
                             (r_fandp_seen || FandP);

`ifdef AIRLOCK_TIMEOUT_EN
  assign w_fill_late = (w_count == LD_FANDP_LAST) && !r_fandp_seen && !FandP;
`else
  assign w_fill_late = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_next_dir = r_dir;
    case (r_state)
      S_IDLE: begin
        if (ArriveReq) begin
          w_next     = S_OUTER_OPEN;
          w_next_dir = DIR_ARRIVE;
        end else if (DepartReq) begin
          w_next     = S_FILL;
          w_next_dir = DIR_DEPART;
        end
      end
      S_OUTER_OPEN: begin
        if (w_done) w_next = S_OUTER_WAIT;
      end
      S_OUTER_WAIT: begin
        if (OuterClosed) begin
          w_next = (r_dir == DIR_ARRIVE) ? S_FILL : S_IDLE;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (w_done) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_FILL: begin
        // An open door while pressurizing outranks every other condition.
        if (!OuterClosed || !InnerClosed) begin
          w_next = S_FAULT;
        end else if (Pressurized) begin
          w_next = S_INNER_OPEN;
        end else if (w_fill_late) begin
          w_next = S_FAULT;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (w_done) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_INNER_OPEN: begin
        if (w_done) w_next = S_INNER_WAIT;
      end
      S_INNER_WAIT: begin
        if (InnerClosed) begin
          w_next = S_EVAC;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (w_done) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_EVAC: begin
        if (Depressurized) begin
          w_next = (r_dir == DIR_ARRIVE) ? S_IDLE : S_OUTER_OPEN;
        end
`ifdef AIRLOCK_TIMEOUT_EN
        else if (w_done) begin
          w_next = S_FAULT;
        end
`endif
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // The timer restarts on every state change; in wait states it only matters
  // when the watchdogs are built in.
  assign w_load = (w_next != r_state);

  always_comb begin
    w_load_value = '0;
    case (w_next)
      S_OUTER_OPEN, S_INNER_OPEN: w_load_value = LD_DWELL;
      S_FILL, S_EVAC:             w_load_value = LD_FILL;
      S_OUTER_WAIT, S_INNER_WAIT: w_load_value = LD_DOOR;
      default:                    w_load_value = '0;
    endcase
  end

  assign w_outs      = decode_outputs(r_state);
  assign OpenOuter   = w_outs.open_outer;
  assign OpenInner   = w_outs.open_inner;
  assign begin_FandP = w_outs.begin_fandp;
  assign begin_Evac  = w_outs.begin_evac;
  assign Busy        = w_outs.busy;
  assign Fault       = w_outs.fault;

  assign o_dbg_state      = r_state;
  assign o_dbg_dir        = r_dir;
  assign o_dbg_fandp_seen = r_fandp_seen;
  assign o_dbg_count      = w_count;

endmodule
